// File: rtl/imem_boot_ctrl.sv
// Boot loader for the CPU instruction memory: takes a counted big-endian byte
// stream, writes it word by word, then hands the memory read port to the CPU.
module imem_boot_ctrl #(
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rx_valid,
   input  logic [7:0]    rx_data,
   output logic          rx_ready,
   input  logic          reload,
   input  logic          cpu_ce,
   input  logic [31:0]   cpu_addr,
   output logic [31:0]   cpu_inst,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_rdata,
   output logic          cpu_run,
   output logic          err,
   output logic [AW:0]   words_loaded
);

   typedef enum logic [2:0] {HDR_HI, HDR_LO, LOAD, DONE, RUN} state_t;

   localparam logic [16:0]   MAX_N = 17'd1 << AW;
   localparam logic [AW:0]   ONE_W = 1;
   localparam logic [AW-1:0] ONE_P = 1;

   state_t        state;
   logic [7:0]    n_hi;
   logic [15:0]   n_words;
   logic [1:0]    byte_idx;
   logic [23:0]   asm_q;
   logic [AW-1:0] wr_ptr;
   logic          accept;
   logic [15:0]   n_next;
   logic          unused_addr;

   // The write cycle doubles as a one-cycle stall so the pointer can advance.
   assign rx_ready = (state == HDR_HI || state == HDR_LO || state == LOAD) && !mem_we;
   assign accept   = rx_valid & rx_ready;
   assign n_next   = {n_hi, rx_data};

   assign mem_addr    = cpu_run ? cpu_addr[AW+1:2] : wr_ptr;
   assign cpu_inst    = (cpu_run & cpu_ce) ? mem_rdata : 32'h0;
   assign unused_addr = ^{cpu_addr[31:AW+2], cpu_addr[1:0]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= HDR_HI;
         n_hi         <= '0;
         n_words      <= '0;
         byte_idx     <= '0;
         asm_q        <= '0;
         wr_ptr       <= '0;
         words_loaded <= '0;
         mem_we       <= 1'b0;
         mem_wdata    <= '0;
         cpu_run      <= 1'b0;
         err          <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         if (mem_we) wr_ptr <= wr_ptr + ONE_P;
         case (state)
            HDR_HI: begin
               if (accept) begin
                  n_hi  <= rx_data;
                  state <= HDR_LO;
               end
            end
            HDR_LO: begin
               if (accept) begin
                  n_words <= n_next;
                  if (n_next == 16'd0 || {1'b0, n_next} > MAX_N) begin
                     err   <= 1'b1;
                     state <= HDR_HI;
                  end else begin
                     words_loaded <= '0;
                     byte_idx     <= '0;
                     wr_ptr       <= '0;
                     state        <= LOAD;
                  end
               end
            end
            LOAD: begin
               // Leave only once the final write strobe is actually on the bus.
               if (mem_we && 17'(words_loaded) == 17'(n_words)) begin
                  state <= DONE;
               end else if (accept) begin
                  byte_idx <= byte_idx + 2'd1;
                  asm_q    <= {asm_q[15:0], rx_data};
                  if (byte_idx == 2'd3) begin
                     mem_we       <= 1'b1;
                     mem_wdata    <= {asm_q, rx_data};
                     words_loaded <= words_loaded + ONE_W;
                  end
               end
            end
            DONE: begin
               cpu_run <= 1'b1;
               state   <= RUN;
            end
            RUN: begin
               if (reload) begin
                  cpu_run <= 1'b0;
                  err     <= 1'b0;
                  state   <= HDR_HI;
               end
            end
            default: state <= HDR_HI;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Bench for imem_boot_ctrl: random byte streams against a stream-level model
// of which words should land at which addresses.
module tb_imem_boot_ctrl;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          rx_valid = 1'b0;
   logic [7:0]    rx_data = 8'h0;
   logic          rx_ready;
   logic          reload = 1'b0;
   logic          cpu_ce = 1'b0;
   logic [31:0]   cpu_addr = 32'h0;
   logic [31:0]   cpu_inst;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;
   logic          cpu_run;
   logic          err;
   logic [AW:0]   words_loaded;

   imem_boot_ctrl #(.AW(AW)) dut (
      .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
      .reload(reload), .cpu_ce(cpu_ce), .cpu_addr(cpu_addr), .cpu_inst(cpu_inst),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .cpu_run(cpu_run), .err(err), .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   logic [31:0] tbmem [0:(1<<AW)-1];
   assign mem_rdata = tbmem[mem_addr];
   always @(posedge clk) if (mem_we) tbmem[mem_addr] <= mem_wdata;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [AW-1:0] wq_addr[$];
   logic [31:0]   wq_data[$];
   int last_we_cyc = 0;
   int we_while_run = 0;
   int we_while_ready = 0;
   always @(negedge clk) begin
      if (mem_we) begin
         wq_addr.push_back(mem_addr);
         wq_data.push_back(mem_wdata);
         last_we_cyc = cyc;
         if (cpu_run) we_while_run++;
         if (rx_ready) we_while_ready++;
      end
   end

   int total = 0;
   int bad = 0;
   logic [7:0]  stream[$];
   logic [31:0] exp_words[$];
   int exp_n;
   bit exp_ok;
   bit exp_err = 1'b0;
   int stalls;
   int run_cyc;
   logic [31:0] pre_inst;
   logic pre_run;
   int nbad;

   // Model: header gives N; legal N in 1..2^AW; word i = bytes 2+4i..5+4i big-endian at address i.
   task automatic build_model();
      exp_n  = int'({stream[0], stream[1]});
      exp_ok = (exp_n >= 1) && (exp_n <= (1 << AW));
      exp_words.delete();
      if (!exp_ok) exp_err = 1'b1;
      else
         for (int i = 0; i < exp_n; i++)
            if (stream.size() >= 2 + 4 * (i + 1))
               exp_words.push_back({stream[2+4*i], stream[3+4*i], stream[4+4*i], stream[5+4*i]});
   endtask

   task automatic make_stream(input int n);
      stream.delete();
      stream.push_back(8'(n >> 8));
      stream.push_back(8'(n));
      for (int i = 0; i < 4 * n; i++) stream.push_back(8'($urandom));
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap, input bit rnd_rel, output int st);
      int guard;
      st = 0;
      if (gap > 0) begin
         rx_valid = 1'b0;
         repeat (gap) begin
            rx_data = 8'($urandom);
            @(negedge clk);
         end
      end
      rx_valid = 1'b1;
      rx_data  = b;
      reload   = rnd_rel ? 1'($urandom_range(0, 1)) : 1'b0;
      guard = 0;
      while (!rx_ready && guard < 20) begin
         guard++;
         st++;
         @(negedge clk);
      end
      total++;
      if (!rx_ready) begin
         bad++;
         $display("FAIL byte_accept: rx_ready=%b required 1 within 20 cycles", rx_ready);
      end
      @(negedge clk);
      reload = 1'b0;
   endtask

   task automatic run_stream(input int gap_max, input bit rnd_rel, input bit wait_run);
      int st, guard;
      wq_addr.delete();
      wq_data.delete();
      we_while_run = 0;
      we_while_ready = 0;
      build_model();
      stalls = 0;
      foreach (stream[i]) begin
         send_byte(stream[i], $urandom_range(0, gap_max), rnd_rel, st);
         stalls += st;
      end
      rx_valid = 1'b0;
      pre_inst = cpu_inst;
      pre_run  = cpu_run;
      if (wait_run) begin
         guard = 0;
         while (!cpu_run && guard < 30) begin
            @(negedge clk);
            guard++;
         end
         run_cyc = cyc;
         total++;
         if (!cpu_run) begin
            bad++;
            $display("FAIL run_timeout: cpu_run=%b required 1 after load", cpu_run);
         end
      end
   endtask

   task automatic go_idle();
      if (cpu_run) begin
         reload = 1'b1;
         @(negedge clk);
         reload = 1'b0;
         exp_err = 1'b0;
      end
   endtask

   task automatic test_reset();
      cpu_ce = 1'b1;
      cpu_addr = 32'h8;
      #2;
      total++;
      if ({rx_ready, cpu_run, mem_we, err} !== 4'b1000) begin
         bad++;
         $display("FAIL reset_ctrl: ready/run/we/err=%b required 1000", {rx_ready, cpu_run, mem_we, err});
      end
      total++;
      if (mem_wdata !== 32'h0 || words_loaded !== 11'h0 || mem_addr !== 10'h0 || cpu_inst !== 32'h0) begin
         bad++;
         $display("FAIL reset_data: wdata=%h words=%0d addr=%0d inst=%h required all 0",
                  mem_wdata, words_loaded, mem_addr, cpu_inst);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_program();
      stream = '{8'h00, 8'h03, 8'h3C, 8'h01, 8'h70, 8'h00, 8'h3C, 8'h02, 8'h70, 8'h00,
                 8'h08, 8'h00, 8'h00, 8'h04};
      cpu_ce = 1'b1;
      cpu_addr = 32'h8;
      run_stream(0, 1'b0, 1'b1);
      nbad = 0;
      foreach (exp_words[i])
         if (i >= wq_data.size() || wq_data[i] !== exp_words[i] || int'(wq_addr[i]) != i) nbad++;
      total++;
      if (wq_data.size() != 3 || nbad != 0) begin
         bad++;
         $display("FAIL prog_writes: %0d writes, %0d wrong, required 3 correct", wq_data.size(), nbad);
      end
      total++;
      if (words_loaded !== 11'd3) begin
         bad++;
         $display("FAIL prog_count: words_loaded=%0d required 3", words_loaded);
      end
      total++;
      if (run_cyc - last_we_cyc != 2) begin
         bad++;
         $display("FAIL prog_run_delay: %0d cycles after last write, required 2", run_cyc - last_we_cyc);
      end
      total++;
      if (pre_run !== 1'b0 || pre_inst !== 32'h0) begin
         bad++;
         $display("FAIL prog_pre_fetch: run=%b inst=%h required 0/00000000", pre_run, pre_inst);
      end
      total++;
      if (mem_addr !== 10'd2 || cpu_inst !== 32'h08000004) begin
         bad++;
         $display("FAIL prog_fetch: addr=%0d inst=%h required 2/08000004", mem_addr, cpu_inst);
      end
   endtask

   task automatic test_bad_header();
      logic [7:0] hdrs[4];
      hdrs = '{8'h00, 8'h00, 8'h04, 8'h01};
      go_idle();
      for (int h = 0; h < 2; h++) begin
         stream = '{hdrs[2*h], hdrs[2*h+1]};
         run_stream(1, 1'b0, 1'b0);
         repeat (3) @(negedge clk);
         total++;
         if (err !== exp_err || wq_data.size() != 0 || cpu_run !== 1'b0 || rx_ready !== 1'b1) begin
            bad++;
            $display("FAIL bad_header_%0d: err=%b writes=%0d run=%b ready=%b required 1/0/0/1",
                     h, err, wq_data.size(), cpu_run, rx_ready);
         end
      end
   endtask

   task automatic test_back_to_back();
      int idx;
      make_stream($urandom_range(2, 6));
      run_stream(0, 1'b1, 1'b1);
      nbad = 0;
      foreach (exp_words[i])
         if (i >= wq_data.size() || wq_data[i] !== exp_words[i] || int'(wq_addr[i]) != i) nbad++;
      total++;
      if (wq_data.size() != exp_n || nbad != 0) begin
         bad++;
         $display("FAIL b2b_writes: %0d writes, %0d wrong, required %0d", wq_data.size(), nbad, exp_n);
      end
      total++;
      if (stalls != exp_n - 1 || we_while_ready != 0) begin
         bad++;
         $display("FAIL b2b_stalls: stalls=%0d ready_during_we=%0d required %0d/0",
                  stalls, we_while_ready, exp_n - 1);
      end
      total++;
      if (err !== exp_err || words_loaded !== 11'(exp_n)) begin
         bad++;
         $display("FAIL b2b_status: err=%b words=%0d required %b/%0d", err, words_loaded, exp_err, exp_n);
      end
      for (int j = 0; j < 6; j++) begin
         idx = $urandom_range(0, exp_n - 1);
         cpu_addr = $urandom;
         cpu_addr[AW+1:2] = idx[AW-1:0];
         #1;
         total++;
         if (int'(mem_addr) != idx || cpu_inst !== exp_words[idx]) begin
            bad++;
            $display("FAIL b2b_fetch: addr=%0d inst=%h required %0d/%h", mem_addr, cpu_inst, idx, exp_words[idx]);
         end
      end
      cpu_ce = 1'b0;
      #1;
      total++;
      if (cpu_inst !== 32'h0) begin
         bad++;
         $display("FAIL fetch_ce_off: inst=%h required 00000000", cpu_inst);
      end
      cpu_ce = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_run_reload();
      wq_data.delete();
      rx_valid = 1'b1;
      for (int j = 0; j < 5; j++) begin
         rx_data = 8'($urandom);
         @(negedge clk);
         total++;
         if (rx_ready !== 1'b0) begin
            bad++;
            $display("FAIL run_rx_ready: rx_ready=%b required 0", rx_ready);
         end
      end
      rx_valid = 1'b0;
      total++;
      if (wq_data.size() != 0 || cpu_run !== 1'b1) begin
         bad++;
         $display("FAIL run_hold: writes=%0d run=%b required 0/1", wq_data.size(), cpu_run);
      end
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
      exp_err = 1'b0;
      total++;
      if ({cpu_run, rx_ready, err} !== 3'b010) begin
         bad++;
         $display("FAIL reload_resp: run/ready/err=%b required 010", {cpu_run, rx_ready, err});
      end
      stream = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      run_stream(1, 1'b0, 1'b1);
      total++;
      if (wq_data.size() != 1 || wq_addr[0] !== 10'd0 || wq_data[0] !== 32'hDEADBEEF || cpu_run !== 1'b1) begin
         bad++;
         $display("FAIL reload_load: writes=%0d addr=%0d data=%h run=%b required 1/0/deadbeef/1",
                  wq_data.size(), wq_addr[0], wq_data[0], cpu_run);
      end
   endtask

   task automatic test_full_depth();
      go_idle();
      make_stream(1 << AW);
      run_stream(0, 1'b0, 1'b1);
      nbad = 0;
      foreach (exp_words[i])
         if (i >= wq_data.size() || wq_data[i] !== exp_words[i] || int'(wq_addr[i]) != i) nbad++;
      total++;
      if (wq_data.size() != (1 << AW) || nbad != 0 || we_while_run != 0) begin
         bad++;
         $display("FAIL full_writes: %0d writes, %0d wrong, %0d while running, required 1024/0/0",
                  wq_data.size(), nbad, we_while_run);
      end
      total++;
      if (words_loaded !== 11'd1024) begin
         bad++;
         $display("FAIL full_count: words_loaded=%0d required 1024", words_loaded);
      end
   endtask

   task automatic test_reset_midload();
      go_idle();
      make_stream(2);
      stream = stream[0:7];
      run_stream(0, 1'b0, 1'b0);
      #2 rst = 1'b0;
      #1;
      exp_err = 1'b0;
      total++;
      if ({cpu_run, mem_we, err, rx_ready} !== 4'b0001 || mem_wdata !== 32'h0 ||
          words_loaded !== 11'h0 || mem_addr !== 10'h0 || cpu_inst !== 32'h0) begin
         bad++;
         $display("FAIL midload_reset: run/we/err/ready=%b wdata=%h words=%0d addr=%0d inst=%h required 0001/0/0/0/0",
                  {cpu_run, mem_we, err, rx_ready}, mem_wdata, words_loaded, mem_addr, cpu_inst);
      end
      @(negedge clk);
      rst = 1'b1;
      make_stream(1);
      run_stream(1, 1'b0, 1'b1);
      total++;
      if (wq_data.size() != 1 || wq_addr[0] !== 10'd0 || wq_data[0] !== exp_words[0] || words_loaded !== 11'd1) begin
         bad++;
         $display("FAIL midload_fresh: writes=%0d addr=%0d data=%h words=%0d required 1/0/%h/1",
                  wq_data.size(), wq_addr[0], wq_data[0], words_loaded, exp_words[0]);
      end
   endtask

   task automatic test_random_gaps();
      for (int r = 0; r < 3; r++) begin
         go_idle();
         make_stream($urandom_range(1, 5));
         run_stream(2, 1'b1, 1'b1);
         nbad = 0;
         foreach (exp_words[i])
            if (i >= wq_data.size() || wq_data[i] !== exp_words[i] || int'(wq_addr[i]) != i) nbad++;
         total++;
         if (wq_data.size() != exp_n || nbad != 0 || words_loaded !== 11'(exp_n) || we_while_run != 0) begin
            bad++;
            $display("FAIL random_load_%0d: writes=%0d wrong=%0d words=%0d required %0d correct",
                     r, wq_data.size(), nbad, words_loaded, exp_n);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_program();
      test_bad_header();
      test_back_to_back();
      test_run_reload();
      test_full_depth();
      test_reset_midload();
      test_random_gaps();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/imem_boot_ctrl.md
# imem_boot_ctrl

Boot-loader and access controller for the single-port 1024-word instruction memory of the single-cycle CPU. It receives a program as a byte stream from the board's serial receiver and writes it into instruction memory one word at a time. While loading, it holds the CPU stopped. It then hands the memory read port to the CPU fetch path. A `reload` pulse stops the CPU and returns the controller to loading.

## Interface
Parameters:
- `AW`, 10, word-address width of instruction memory (depth = 2^AW words).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `rx_valid`  in  1  byte available from the serial receiver.
- `rx_data`  in  8  byte value.
- `rx_ready`  out  1  controller accepts a byte; a transfer occurs when `rx_valid & rx_ready`.
- `reload`  in  1  single-cycle request to stop the CPU and reload; honoured only in RUN.
- `cpu_ce`  in  1  fetch enable from the PC unit.
- `cpu_addr`  in  32  byte address of the fetch.
- `cpu_inst`  out  32  instruction returned to the CPU.
- `mem_addr`  out  AW  instruction-memory word address.
- `mem_we`  out  1  instruction-memory write strobe.
- `mem_wdata`  out  32  write data.
- `mem_rdata`  in  32  instruction-memory read data (combinational read).
- `cpu_run`  out  1  CPU release; 0 holds the PC in reset.
- `err`  out  1  sticky flag: illegal header was received.
- `words_loaded`  out  AW+1  count of words written in the current load.

## Operation
- States: HDR_HI, HDR_LO, LOAD, DONE, RUN. Reset state is HDR_HI.
- Stream format: 16-bit big-endian word count N, followed by N×4 program bytes. Each word is big-endian (first byte → bits 31:24).
- HDR_HI: an accepted byte is stored as N[15:8], then go to HDR_LO.
- HDR_LO: an accepted byte is stored as N[7:0].
  - If N == 0 or N > 2^AW: set `err`, return to HDR_HI, write nothing.
  - Otherwise: clear `words_loaded` and the byte index, then go to LOAD.
- LOAD: accepted bytes are shifted into a 32-bit assembly register.
  - On the 4th byte of a word, the write is issued: registered `mem_we`=1 for exactly one cycle, `mem_wdata` = assembled word, `mem_addr` = write pointer (starts at 0 and increments after each write). `words_loaded` increments in the same cycle.
  - When the write of word N−1 is issued, go to DONE.
- DONE: one-cycle state; `cpu_run` ← 1, go to RUN.
- RUN: `rx_ready`=0. Any `rx_valid` is ignored, not consumed.
  - `reload`=1: `cpu_run` ← 0, go to HDR_HI, clear `err`. The memory contents are left untouched until overwritten.
- `rx_ready` = 1 in HDR_HI, HDR_LO and LOAD, except in the cycle `mem_we` is high. That cycle is a one-cycle stall, so a back-to-back byte waits.
- Address mux (combinational):
  - `cpu_run`=1: `mem_addr` = `cpu_addr[AW+1:2]`.
  - Otherwise: `mem_addr` = write pointer.
- `cpu_inst` = `mem_rdata` when `cpu_run & cpu_ce`, else 32'h0 (reads as a NOP).
- `mem_we` never asserts while `cpu_run`=1.
- `words_loaded` is AW+1 bits, so that a full load of 2^AW words does not wrap. The write pointer is AW bits and wraps to 0 only after the final word, at which point it is unused.

## Timing
- Reset values:
  - HDR_HI state, `rx_ready`=1.
  - `cpu_run`=0, `mem_we`=0, `mem_wdata`=0, write pointer 0, `words_loaded`=0, `err`=0, `cpu_inst`=0.
  - `mem_addr`=0.
- Byte to write: the 4th byte is accepted at edge k, and `mem_we` is high during cycle k+1, sampled by the memory at edge k+2.
- Last write to run: `mem_we` for word N−1 is in cycle k+1, DONE in cycle k+2, and `cpu_run`=1 from cycle k+3.
- `reload`: sampled at edge t; `cpu_run`=0 and `rx_ready`=1 from cycle t+1.
- `reload` in any state other than RUN is ignored.
- `rst` asserted mid-load: all state clears immediately (asynchronous). Partially written memory is not erased, and the next stream must start with a header.
- Fetch path is combinational: zero added latency to the CPU.

## Test plan
- Header 0x0003 + 12 bytes (3C 01 70 00, 3C 02 70 00, 08 00 00 04) at one byte per cycle → `mem_we` pulses write 0x3C017000@0, 0x3C027000@1, 0x08000004@2. `words_loaded`=3, and `cpu_run` rises 2 cycles after the last `mem_we`.
- Before `cpu_run`, `cpu_ce`=1 and `cpu_addr`=0x8 → `cpu_inst`=0. After `cpu_run`, `cpu_addr`=0x8 → `mem_addr`=2 and `cpu_inst`=0x08000004.
- Header 0x0000, then a separate run with header 0x0401 → `err`=1 in each case, no `mem_we`, state back to HDR_HI, `cpu_run` stays 0.
- `rx_valid` held high continuously during LOAD → exactly one stall cycle per word (`rx_ready`=0 while `mem_we`=1), and no byte is lost or duplicated.
- In RUN: drive `rx_valid`=1 → `rx_ready` stays 0. Pulse `reload` → `cpu_run`=0 next cycle; a new 1-word load of 0xDEADBEEF writes address 0, and `cpu_run` returns to 1.
- Assert `rst` after 2 of 4 bytes of word 1 → all outputs return to reset values immediately. A fresh 1-word stream then loads correctly, with no stale byte merged into the word.
